// File: rtl/parabrisa_pkg.sv
// Shared types and helpers for the windshield-wiper controller.
// Wiper states are ordered by intensity so that plain comparison ranks them.
package parabrisa_pkg;

  typedef enum logic [1:0] {
    DESLIGADO    = 2'd0,
    INTERMITENTE = 2'd1,
    BAIXA        = 2'd2,
    ALTA         = 2'd3
  } estado_t;

  typedef enum logic [1:0] {
    AUTO    = 2'd0,
    F_DESL  = 2'd1,
    F_BAIXA = 2'd2,
    F_ALTA  = 2'd3
  } modo_t;

  function automatic estado_t classify_level(input int cnt, input int int_th,
                                             input int low_th, input int high_th);
    estado_t lvl;
    if (cnt >= high_th) begin
      lvl = ALTA;
    end else if (cnt >= low_th) begin
      lvl = BAIXA;
    end else if (cnt >= int_th) begin
      lvl = INTERMITENTE;
    end else begin
      lvl = DESLIGADO;
    end
    return lvl;
  endfunction

  function automatic logic is_upgrade(input estado_t lvl, input estado_t cur);
    return (lvl > cur);
  endfunction

endpackage

// File: rtl/parabrisa_popcount.sv
// Combinational count of asserted rain-sensor bits.
module parabrisa_popcount #(
  parameter int N_SENS = 7,
  parameter int CNT_W  = $clog2(N_SENS + 1)
) (
  input  logic [N_SENS-1:0] bits,
  output logic [CNT_W-1:0]  count
);

  // Sum of all sensor bits
  always_comb begin
    count = '0;
    for (int i = 0; i < N_SENS; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/parabrisa_ctrl.sv
// Wiper controller: drop counting, persistence-filtered state selection,
// intermittent wipe pulse and manual override.
module parabrisa_ctrl
  import parabrisa_pkg::*;
#(
  parameter int N_SENS     = 7,
  parameter int CNT_W      = $clog2(N_SENS + 1),
  parameter int INT_TH     = 2,
  parameter int LOW_TH     = 4,
  parameter int HIGH_TH    = 6,
  parameter int PERS_UP    = 3,
  parameter int PERS_DOWN  = 2,
  parameter int INT_PERIOD = 4
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic              tick,
  input  logic [N_SENS-1:0] chuva,
  input  logic [1:0]        modo,
  output logic [1:0]        estado,
  output logic              motor,
  output logic [CNT_W-1:0]  num_gotas
);

  localparam int PERS_MAX = (PERS_UP > PERS_DOWN) ? PERS_UP : PERS_DOWN;
  localparam int PC_W     = $clog2(PERS_MAX + 1);
  localparam int PER_W    = $clog2(INT_PERIOD);

  if (!(INT_TH >= 1 && INT_TH <= LOW_TH && LOW_TH <= HIGH_TH && HIGH_TH <= N_SENS &&
        PERS_UP >= 1 && PERS_DOWN >= 1 && INT_PERIOD >= 2)) begin : g_param_check
    $error("parabrisa_ctrl: inconsistent threshold/persistence/period parameters");
  end

  estado_t          estado_q, estado_d, cand_q, cand_d, level;
  logic [PC_W-1:0]  pers_cnt_q, pers_cnt_d, n_cnt, req_cnt;
  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] num_gotas_q, num_gotas_d;
  logic             motor_q, motor_d, pulse;

  parabrisa_popcount #(.N_SENS(N_SENS), .CNT_W(CNT_W)) u_popcount (
    .bits  (chuva),
    .count (num_gotas_d)
  );

  assign level = classify_level(int'(num_gotas_q), INT_TH, LOW_TH, HIGH_TH);

  // Next state, persistence filter, intermittent period and motor drive
  always_comb begin
    estado_d   = estado_q;
    cand_d     = cand_q;
    pers_cnt_d = pers_cnt_q;
    per_cnt_d  = per_cnt_q;
    n_cnt      = '0;
    req_cnt    = '0;
    pulse      = 1'b0;
    motor_d    = 1'b0;

    case (modo_t'(modo))
      AUTO: begin
        if (tick) begin
          if (level == estado_q) begin
            pers_cnt_d = '0;
            cand_d     = DESLIGADO;
          end else begin
            if (level == cand_q) begin
              n_cnt = (pers_cnt_q == PC_W'(PERS_MAX)) ? pers_cnt_q : pers_cnt_q + PC_W'(1);
            end else begin
              n_cnt = PC_W'(1);
            end
            cand_d  = level;
            req_cnt = is_upgrade(level, estado_q) ? PC_W'(PERS_UP) : PC_W'(PERS_DOWN);
            if (n_cnt >= req_cnt) begin
              estado_d   = level;
              pers_cnt_d = '0;
            end else begin
              pers_cnt_d = n_cnt;
            end
          end
        end else begin
          estado_d = estado_q;
        end
      end
      F_DESL: begin
        estado_d   = DESLIGADO;
        cand_d     = DESLIGADO;
        pers_cnt_d = '0;
      end
      F_BAIXA: begin
        estado_d   = BAIXA;
        cand_d     = DESLIGADO;
        pers_cnt_d = '0;
      end
      F_ALTA: begin
        estado_d   = ALTA;
        cand_d     = DESLIGADO;
        pers_cnt_d = '0;
      end
      default: begin
        estado_d = estado_q;
      end
    endcase

    // Period counts ticks spent in INTERMITENTE; leaving that state restarts it
    if (tick && (estado_q == INTERMITENTE)) begin
      if (per_cnt_q == PER_W'(INT_PERIOD - 1)) begin
        per_cnt_d = '0;
        pulse     = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + PER_W'(1);
      end
    end else begin
      per_cnt_d = per_cnt_q;
    end
    if (estado_d != INTERMITENTE) begin
      per_cnt_d = '0;
    end else begin
      per_cnt_d = per_cnt_d;
    end

    case (estado_d)
      DESLIGADO:    motor_d = 1'b0;
      INTERMITENTE: motor_d = pulse;
      BAIXA, ALTA:  motor_d = 1'b1;
      default:      motor_d = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      estado_q    <= DESLIGADO;
      cand_q      <= DESLIGADO;
      pers_cnt_q  <= '0;
      per_cnt_q   <= '0;
      num_gotas_q <= '0;
      motor_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cand_q      <= cand_d;
      pers_cnt_q  <= pers_cnt_d;
      per_cnt_q   <= per_cnt_d;
      num_gotas_q <= num_gotas_d;
      motor_q     <= motor_d;
    end
  end

  assign estado    = estado_q;
  assign motor     = motor_q;
  assign num_gotas = num_gotas_q;

endmodule

// File: tb/tb_parabrisa_ctrl.sv
// Self-checking bench for parabrisa_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the wiper rules.
module tb_parabrisa_ctrl;

  localparam int N_SENS     = 7;
  localparam int CNT_W      = 3;
  localparam int INT_TH     = 2;
  localparam int LOW_TH     = 4;
  localparam int HIGH_TH    = 6;
  localparam int PERS_UP    = 3;
  localparam int PERS_DOWN  = 2;
  localparam int INT_PERIOD = 4;

  logic             clk_2 = 1'b0;
  logic             reset;
  logic             tick;
  logic [6:0]       chuva;
  logic [1:0]       modo;
  logic [1:0]       estado;
  logic             motor;
  logic [CNT_W-1:0] num_gotas;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: wiper state, candidate level, persistence, period, outputs
  int m_est, m_cand, m_pers, m_per, m_motor, m_g;

  always #5 clk_2 = ~clk_2;

  parabrisa_ctrl #(
    .N_SENS(N_SENS), .CNT_W(CNT_W), .INT_TH(INT_TH), .LOW_TH(LOW_TH),
    .HIGH_TH(HIGH_TH), .PERS_UP(PERS_UP), .PERS_DOWN(PERS_DOWN), .INT_PERIOD(INT_PERIOD)
  ) dut (
    .clk_2(clk_2), .reset(reset), .tick(tick), .chuva(chuva), .modo(modo),
    .estado(estado), .motor(motor), .num_gotas(num_gotas)
  );

  function automatic int lvl(input int g);
    if (g >= HIGH_TH) return 3;
    if (g >= LOW_TH)  return 2;
    if (g >= INT_TH)  return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_est = 0; m_cand = 0; m_pers = 0; m_per = 0; m_motor = 0; m_g = 0;
  endtask

  // What the next rising edge should produce, from the current inputs
  task automatic model_update();
    int L, n, req, est_old;
    bit pulse;
    if (!reset) begin
      model_reset();
      return;
    end
    est_old = m_est;
    pulse   = 0;
    if (modo != 2'd0) begin
      m_est  = (modo == 2'd1) ? 0 : int'(modo);
      m_cand = 0;
      m_pers = 0;
    end else if (tick) begin
      L = lvl(m_g);
      if (L == m_est) begin
        m_pers = 0;
        m_cand = 0;
      end else begin
        n      = (L == m_cand) ? m_pers + 1 : 1;
        m_cand = L;
        req    = (L > m_est) ? PERS_UP : PERS_DOWN;
        if (n >= req) begin
          m_est  = L;
          m_pers = 0;
        end else begin
          m_pers = n;
        end
      end
    end
    if (tick && est_old == 1) begin
      if (m_per == INT_PERIOD - 1) begin
        pulse = 1;
        m_per = 0;
      end else begin
        m_per++;
      end
    end
    if (m_est != 1) m_per = 0;
    m_motor = (m_est == 0) ? 0 : ((m_est == 1) ? int'(pulse) : 1);
    m_g = $countones(chuva);
  endtask

  task automatic step(input logic tk);
    tick = tk;
    model_update();
    @(posedge clk_2);
    #1;
    tick = 1'b0;
    check("estado", 8'(estado), 8'(m_est));
    check("motor", 8'(motor), 8'(m_motor));
    check("num_gotas", 8'(num_gotas), 8'(m_g));
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      step(1'b0); step(1'b0); step(1'b0); step(1'b1);
    end
  endtask

  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_estado", 8'(estado), 8'd0);
    check("rst_motor", 8'(motor), 8'd0);
    check("rst_gotas", 8'(num_gotas), 8'd0);
    model_reset();
    step(1'b0);
    reset = 1'b1;
  endtask

  initial begin
    int k, v, r;
    reset = 1'b0; tick = 1'b0; chuva = 7'd0; modo = 2'd0;
    model_reset();
    #3;
    check("init_estado", 8'(estado), 8'd0);
    check("init_motor", 8'(motor), 8'd0);
    check("init_gotas", 8'(num_gotas), 8'd0);
    step(1'b0);
    reset = 1'b1;

    // Reset while in ALTA with a partial downgrade pending
    chuva = 7'h7F;
    run_ticks(3);
    check("reach_alta", 8'(estado), 8'd3);
    chuva = 7'd0;
    run_ticks(1);
    check("alta_pending", 8'(estado), 8'd3);
    async_reset();
    chuva = 7'b0001111;
    run_ticks(2);
    check("baixa_not_yet", 8'(estado), 8'd0);
    run_ticks(1);
    check("baixa_3rd_tick", 8'(estado), 8'd2);
    check("baixa_motor", 8'(motor), 8'd1);

    // Candidate restart: BAIXA candidate replaced by ALTA
    chuva = 7'd0;
    run_ticks(2);
    check("back_desl", 8'(estado), 8'd0);
    chuva = 7'b0001111;
    for (int t = 1; t <= 5; t++) begin
      if (t == 3) chuva = 7'b0111111;
      run_ticks(1);
      check("restart_estado", 8'(estado), (t == 5) ? 8'd3 : 8'd0);
    end
    check("restart_motor", 8'(motor), 8'd1);

    // Intermittent pulses
    chuva = 7'd0;
    run_ticks(2);
    check("int_pre_desl", 8'(estado), 8'd0);
    chuva = 7'b0000011;
    for (int t = 1; t <= 15; t++) begin
      run_ticks(1);
      check("int_estado", 8'(estado), (t >= 3) ? 8'd1 : 8'd0);
      check("int_pulse", 8'(motor), (t == 7 || t == 11 || t == 15) ? 8'd1 : 8'd0);
    end
    step(1'b0);
    check("int_pulse_end", 8'(motor), 8'd0);

    // Downgrade persistence and direct jump to DESLIGADO
    chuva = 7'h7F;
    run_ticks(3);
    check("dg_alta", 8'(estado), 8'd3);
    chuva = 7'd0;
    run_ticks(1);
    check("dg_hold1", 8'(estado), 8'd3);
    chuva = 7'h7F;
    run_ticks(1);
    check("dg_hold2", 8'(estado), 8'd3);
    chuva = 7'd0;
    run_ticks(1);
    check("dg_hold3", 8'(estado), 8'd3);
    run_ticks(1);
    check("dg_desl", 8'(estado), 8'd0);
    check("dg_motor", 8'(motor), 8'd0);

    // Override without tick, return to AUTO, forced beats simultaneous tick
    modo = 2'd3;
    step(1'b0);
    check("ovr_alta", 8'(estado), 8'd3);
    modo = 2'd0;
    run_ticks(1);
    check("ovr_hold", 8'(estado), 8'd3);
    run_ticks(1);
    check("ovr_desl", 8'(estado), 8'd0);
    modo = 2'd2;
    step(1'b1);
    check("ovr_tick_baixa", 8'(estado), 8'd2);
    modo = 2'd1;
    step(1'b0);
    check("ovr_desl_forced", 8'(estado), 8'd0);
    modo = 2'd0;

    // Full-scale drop count
    chuva = 7'h7F;
    step(1'b0);
    check("full_scale", 8'(num_gotas), 8'd7);
    chuva = 7'd0;
    step(1'b0);
    check("zero_scale", 8'(num_gotas), 8'd0);

    // Randomized traffic with slowly varying drop count
    k = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) k = $urandom_range(0, 7);
      v = (1 << k) - 1;
      r = $urandom_range(0, 6);
      v = ((v << r) | (v >> (7 - r))) & 127;
      chuva = 7'(v);
      if ($urandom_range(0, 31) == 0) modo = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      if (i == 300) async_reset();
      step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
